dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//   Data-memory responder: target side of the CPU load/store interface.
//   Accepts one request at a time over a valid/ready handshake, inserts a
//   fixed number of wait states, then returns a response.
//   Stores commit byte-lane data; loads return lane-aligned, sign- or
//   zero-extended data.
//   Sits between the CPU memory stage and a word-organised on-chip RAM.
// PARAMETERS
//   ADDR_W       14    byte-address width; the RAM holds 2**(ADDR_W-2) words
//   WAIT_STATES  1     wait cycles between accept and response (0..15)
// PORTS
//   clk        in   1       clock, rising edge
//   rst        in   1       asynchronous, active-high reset
//   req_valid  in   1       request present
//   req_ready  out  1       responder can accept a request
//   req_we     in   1       1 = store, 0 = load
//   req_addr   in   ADDR_W  byte address
//   req_wdata  in   32      store data, right-justified
//   req_type   in   3       funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   rsp_valid  out  1       response present
//   rsp_ready  in   1       initiator accepts the response
//   rsp_rdata  out  32      load data after extension; 0 for stores and errors
//   rsp_err    out  1       request rejected; no memory side effect
// BEHAVIOUR
//   Reset: state IDLE, wait counter 0, req_ready=1, rsp_valid=0, rsp_rdata=0,
//     rsp_err=0. RAM contents are not reset.
//   FSM IDLE -> WAIT -> RESP -> IDLE:
//     IDLE: req_ready=1. On req_valid the request is captured and the FSM
//       moves to WAIT (counter=WAIT_STATES-1), or straight to RESP when
//       WAIT_STATES=0.
//     WAIT: counter decrements each cycle; at 0 the FSM moves to RESP on the
//       next edge. req_ready=0.
//     RESP: rsp_valid=1, and rsp_* is held stable until rsp_ready=1. On that
//       edge the FSM returns to IDLE. It does not accept a new request in the
//       same cycle, so there is one bubble per transaction.
//   Latency from accept edge to rsp_valid: WAIT_STATES+1 cycles.
//   Store commit: byte-enabled RAM write on the edge that enters RESP, and
//     exactly once per request.
//     B: lane addr[1:0]. H: lanes {addr[1],0} and {addr[1],1}. W: all lanes.
//   Load read: RAM read on the same edge; rsp_rdata is registered.
//     B/H: sign-extend. BU/HU: zero-extend.
//   Word index is addr[ADDR_W-1:2]; indices wrap at RAM size (no error).
//   Illegal req_type (011, 110, 111; stores using 100 or 101): rsp_err=1,
//     rsp_rdata=0, no write.
//   Misaligned H/W when DMEM_MISALIGN_ERR_EN is not defined: the low address
//     bits are ignored (H aligns to addr[1], W aligns to the word).
//   Reset mid-transaction: the FSM returns to IDLE and the pending request is
//     dropped. A store that has not reached RESP is not written.
// CONFIGURATION
//   DMEM_MISALIGN_ERR_EN defined: H with addr[0]=1, or W with addr[1:0]!=0,
//     gives rsp_err=1, rsp_rdata=0, no write. Timing is unchanged.
//   Undefined: silent alignment as described above; rsp_err is driven only by
//     an illegal req_type.
// STRUCTURE
//   Shared constants go in define.v: funct3 load/store codes (LB, LH, LW, LBU,
//     LHU, SB, SH, SW) and the FSM state encodings.
//   Sub-module dmem_lane_align (combinational):
//     store path: wdata replication and 4-bit byte-enable generation
//     load path: lane select and sign/zero extension
//   The RAM array lives inside dmem_responder as a reg array with a single
//     read/write port.
// TESTING
//   1. SW addr 0x010 data 0xDEADBEEF, then LW 0x010 -> rdata 0xDEADBEEF,
//      rsp_err 0; rsp_valid exactly WAIT_STATES+1 cycles after each accept.
//   2. SB 0x80 to addr 0x013 over word 0x00000000, then LB 0x013 ->
//      0xFFFFFF80, LBU 0x013 -> 0x00000080, LW 0x010 -> 0x80000000.
//   3. SH 0x8001 to 0x022, then LH 0x022 -> 0xFFFF8001,
//      LHU 0x022 -> 0x00008001; lanes 0-1 of word 0x020 unchanged.
//   4. Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable,
//      req_ready=0; a req_valid pulse during the stall is not accepted.
//   5. req_type 011 store to 0x030 -> rsp_err 1; a later LW 0x030 returns the
//      old value. With the macro, LW 0x031 -> rsp_err 1; without it,
//      LW 0x031 -> word at 0x030.
//   6. Assert rst during WAIT of SW 0x040 -> rsp_valid 0, req_ready 1 after
//      reset; LW 0x040 returns the prior contents.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: funct3 access codes and FSM states.
// Pure declarations, no logic.
// Optional build macro DMEM_MISALIGN_ERR_EN selects whether misaligned_access() is used by the top.
package dmem_responder_pkg;

    // Load funct3 codes
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    // Store funct3 codes (only the signed encodings are legal for stores)
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Stores only know B/H/W; the unsigned codes are load-only.
    function automatic logic type_illegal(input logic we, input logic [2:0] f3);
        logic bad;
        case (f3)
            LB, LH, LW: bad = 1'b0;
            LBU, LHU:   bad = we;
            default:    bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Halfwords must sit on an even address, words on a word boundary.
    function automatic logic misaligned_access(input logic [2:0] f3, input logic [1:0] lo);
        logic bad;
        case (f3[1:0])
            2'b01:   bad = lo[0];
            2'b10:   bad = (lo != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between the 32-bit RAM word and the right-justified CPU data.
// Combinational, zero latency.
// No flow control; purely a function of its inputs.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [2:0]  mem_type,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] wword,
    output logic [3:0]  be,
    output logic [31:0] rdata
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Store path: replicate the datum into every lane it could land in, enable only the target lanes.
    // A halfword aligns to addr[1]; addr[0] is ignored here.
    always_comb begin
        wword = wdata;
        be    = 4'b0000;
        case (mem_type[1:0])
            2'b00: begin
                wword = {4{wdata[7:0]}};
                be    = 4'b0001 << addr_lo;
            end
            2'b01: begin
                wword = {2{wdata[15:0]}};
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wword = wdata;
                be    = 4'b1111;
            end
        endcase
    end

    // Load path: pick the addressed lane(s) and extend according to funct3.
    always_comb begin
        rd_byte = rword[8*addr_lo +: 8];
        rd_half = addr_lo[1] ? rword[31:16] : rword[15:0];
        case (mem_type)
            LB:      rdata = {{24{rd_byte[7]}}, rd_byte};
            LH:      rdata = {{16{rd_half[15]}}, rd_half};
            LW:      rdata = rword;
            LBU:     rdata = {24'd0, rd_byte};
            LHU:     rdata = {16'd0, rd_half};
            default: rdata = 32'd0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_STATES wait cycles, then a held response.
// Latency: rsp_valid rises WAIT_STATES+1 edges after the accept edge (accept edge counted).
// Backpressure: response held until rsp_ready; req_ready low from accept until back in IDLE.
// Build macro DMEM_MISALIGN_ERR_EN: flag misaligned H/W accesses as errors instead of aligning silently.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W      = 14,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_type,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int         WORDS     = 2 ** (ADDR_W - 2);
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
    localparam logic       NO_WAIT   = (WAIT_STATES == 0);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        type_q;

    logic [31:0]       mem [WORDS];

    logic              accept;
    logic              enter_resp;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [2:0]        sel_type;
    logic              sel_err;
    logic [ADDR_W-3:0] word_idx;
    logic [31:0]       ram_word;
    logic [31:0]       wword;
    logic [3:0]        be;
    logic [31:0]       ld_data;

    // State register and wait counter; reset drops any pending request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = NO_WAIT ? ST_RESP : ST_WAIT;
                    cnt_d   = WAIT_INIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign accept     = (state_q == ST_IDLE) && req_valid;
    assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);

    // Capture the request on accept so the port may change during the wait.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            type_q  <= 3'd0;
        end else if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            type_q  <= req_type;
        end
    end

    // With zero wait states RESP is entered on the accept edge itself, so the live port is used then.
    assign sel_we    = (state_q == ST_IDLE) ? req_we    : we_q;
    assign sel_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
    assign sel_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
    assign sel_type  = (state_q == ST_IDLE) ? req_type  : type_q;
    assign word_idx  = sel_addr[ADDR_W-1:2];

`ifdef DMEM_MISALIGN_ERR_EN
    assign sel_err = type_illegal(sel_we, sel_type) | misaligned_access(sel_type, sel_addr[1:0]);
`else
    assign sel_err = type_illegal(sel_we, sel_type);
`endif

    assign ram_word = mem[word_idx];

    dmem_lane_align u_align (
        .mem_type (sel_type),
        .addr_lo  (sel_addr[1:0]),
        .wdata    (sel_wdata),
        .rword    (ram_word),
        .wword    (wword),
        .be       (be),
        .rdata    (ld_data)
    );

    // Byte-enabled RAM write, exactly once per legal store, on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (enter_resp && sel_we && !sel_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[word_idx][8*i +: 8] <= wword[8*i +: 8];
                end
            end
        end
    end

    // Response registers load on the edge entering RESP and hold until the next transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else if (enter_resp) begin
            rsp_rdata <= (sel_we || sel_err) ? 32'd0 : ld_data;
            rsp_err   <= sel_err;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder with hand-computed expected values.
// Runs with the default WAIT_STATES=1; expected latency is 2 edges counting the accept edge.
// Honours DMEM_MISALIGN_ERR_EN for the misaligned-load case.
module tb_dmem_responder;

    localparam int WS = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [13:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_type;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] held;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(14), .WAIT_STATES(WS)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_type  (req_type),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request, wait (bounded) for the response, consume it if rsp_ready is high.
    task automatic do_req(input logic we, input logic [13:0] addr, input logic [31:0] wd,
                          input logic [2:0] ty, output logic [31:0] rdata, output logic err,
                          output int cycles);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_type  = ty;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cycles    = 1;
        while (!rsp_valid && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        if (rsp_valid && rsp_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_type  = 3'b010;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_req_ready", 32'(req_ready), 32'd1);
        check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("rst_rsp_rdata", rsp_rdata, 32'd0);
        check_val("rst_rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1. word store then load, latency on both
        do_req(1'b1, 14'h010, 32'hDEADBEEF, 3'b010, rd, er, lat);
        check_val("sw_lat", 32'(lat), 32'(WS + 1));
        check_val("sw_err", 32'(er), 32'd0);
        check_val("sw_rdata", rd, 32'd0);
        do_req(1'b0, 14'h010, 32'h0, 3'b010, rd, er, lat);
        check_val("lw_lat", 32'(lat), 32'(WS + 1));
        check_val("lw_rdata", rd, 32'hDEADBEEF);
        check_val("lw_err", 32'(er), 32'd0);
        check_val("idle_after_rsp", 32'({req_ready, rsp_valid}), 32'b10);

        // 2. byte store into lane 3
        do_req(1'b1, 14'h010, 32'h0, 3'b010, rd, er, lat);
        do_req(1'b1, 14'h013, 32'h00000080, 3'b000, rd, er, lat);
        do_req(1'b0, 14'h013, 32'h0, 3'b000, rd, er, lat);
        check_val("lb_013", rd, 32'hFFFFFF80);
        do_req(1'b0, 14'h013, 32'h0, 3'b100, rd, er, lat);
        check_val("lbu_013", rd, 32'h00000080);
        do_req(1'b0, 14'h010, 32'h0, 3'b010, rd, er, lat);
        check_val("lw_010_after_sb", rd, 32'h80000000);
        do_req(1'b0, 14'h012, 32'h0, 3'b000, rd, er, lat);
        check_val("lb_012", rd, 32'h00000000);

        // 3. halfword store into upper half
        do_req(1'b1, 14'h020, 32'h11223344, 3'b010, rd, er, lat);
        do_req(1'b1, 14'h022, 32'hFFFF8001, 3'b001, rd, er, lat);
        do_req(1'b0, 14'h022, 32'h0, 3'b001, rd, er, lat);
        check_val("lh_022", rd, 32'hFFFF8001);
        do_req(1'b0, 14'h022, 32'h0, 3'b101, rd, er, lat);
        check_val("lhu_022", rd, 32'h00008001);
        do_req(1'b0, 14'h020, 32'h0, 3'b010, rd, er, lat);
        check_val("lw_020_after_sh", rd, 32'h80013344);
        do_req(1'b0, 14'h020, 32'h0, 3'b001, rd, er, lat);
        check_val("lh_020", rd, 32'h00003344);

        // 4. response stall with an ignored request pulse
        do_req(1'b1, 14'h050, 32'h12345678, 3'b010, rd, er, lat);
        rsp_ready = 1'b0;
        do_req(1'b0, 14'h020, 32'h0, 3'b010, rd, er, lat);
        held = rd;
        check_val("stall_first_rdata", held, 32'h80013344);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            req_valid = (c == 2);
            req_we    = 1'b1;
            req_addr  = 14'h050;
            req_wdata = 32'hCAFEF00D;
            req_type  = 3'b010;
            @(posedge clk);
            #1;
            check_val("stall_valid", 32'(rsp_valid), 32'd1);
            check_val("stall_rdata", rsp_rdata, 32'h80013344);
            check_val("stall_ready", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check_val("stall_release", 32'({req_ready, rsp_valid}), 32'b10);
        repeat (2) @(posedge clk);
        #1;
        check_val("stall_no_accept", 32'(rsp_valid), 32'd0);
        do_req(1'b0, 14'h050, 32'h0, 3'b010, rd, er, lat);
        check_val("lw_050_untouched", rd, 32'h12345678);

        // 5. illegal types and misaligned word load
        do_req(1'b1, 14'h030, 32'hA5A5A5A5, 3'b010, rd, er, lat);
        do_req(1'b1, 14'h030, 32'h0, 3'b011, rd, er, lat);
        check_val("st011_err", 32'(er), 32'd1);
        check_val("st011_rdata", rd, 32'd0);
        check_val("st011_lat", 32'(lat), 32'(WS + 1));
        do_req(1'b1, 14'h030, 32'h0, 3'b100, rd, er, lat);
        check_val("st100_err", 32'(er), 32'd1);
        do_req(1'b0, 14'h030, 32'h0, 3'b110, rd, er, lat);
        check_val("ld110_err", 32'(er), 32'd1);
        check_val("ld110_rdata", rd, 32'd0);
        do_req(1'b0, 14'h030, 32'h0, 3'b010, rd, er, lat);
        check_val("lw_030_old", rd, 32'hA5A5A5A5);
        check_val("lw_030_err", 32'(er), 32'd0);
        do_req(1'b0, 14'h031, 32'h0, 3'b010, rd, er, lat);
`ifdef DMEM_MISALIGN_ERR_EN
        check_val("lw_031_err", 32'(er), 32'd1);
        check_val("lw_031_rdata", rd, 32'd0);
`else
        check_val("lw_031_err", 32'(er), 32'd0);
        check_val("lw_031_rdata", rd, 32'hA5A5A5A5);
`endif

        // 6. reset during the wait state of a store
        do_req(1'b1, 14'h040, 32'h0BADC0DE, 3'b010, rd, er, lat);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 14'h040;
        req_wdata = 32'hFFFFFFFF;
        req_type  = 3'b010;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_val("wait_before_rst", 32'({req_ready, rsp_valid}), 32'b00);
        rst = 1'b1;
        #1;
        check_val("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("rst_mid_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        do_req(1'b0, 14'h040, 32'h0, 3'b010, rd, er, lat);
        check_val("lw_040_prior", rd, 32'h0BADC0DE);
        check_val("lw_040_lat", 32'(lat), 32'(WS + 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
